// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: control codes, alu_op classes,
// funct7 patterns and FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_DIVU = 4'b1100;
  localparam logic [3:0] ALU_REM  = 4'b1101;
  localparam logic [3:0] ALU_REMU = 4'b1110;
  localparam logic [3:0] ALU_ILL  = 4'b1111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // funct3 -> code for the plain integer ops shared by R-type and I-type
  function automatic logic [3:0] base_code(input logic [2:0] f3);
    logic [3:0] c;
    case (f3)
      3'b000:  c = ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  function automatic logic is_muldiv(input logic [3:0] c);
    return (c == ALU_MUL) || (c == ALU_DIV) || (c == ALU_DIVU) ||
           (c == ALU_REM) || (c == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// The sh/dv/acc registers are shared between the two modes.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            div_mode,
  input  logic            sgn,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            last,
  output logic [XLEN-1:0] product,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic            busy;
  logic [CW-1:0]   cnt;
  logic            div_q;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] dv;
  logic [XLEN-1:0] acc;

  logic            a_neg_p0;
  logic            b_neg_p0;
  logic [XLEN-1:0] mag_a_p0;
  logic [XLEN-1:0] mag_b_p0;

  logic [XLEN:0]   rem_t;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] sh_nx;
  logic [XLEN-1:0] dv_nx;
  logic [XLEN-1:0] acc_nx;

  assign a_neg_p0 = sgn && op_a[XLEN-1];
  assign b_neg_p0 = sgn && op_b[XLEN-1];
  assign mag_a_p0 = a_neg_p0 ? -op_a : op_a;
  assign mag_b_p0 = b_neg_p0 ? -op_b : op_b;

  assign last = busy && (cnt == CW'(XLEN - 1));

  always_comb begin
    rem_t  = {acc, sh[XLEN-1]};
    diff   = rem_t - {1'b0, dv};
    sh_nx  = sh;
    dv_nx  = dv;
    acc_nx = acc;
    if (div_q) begin
      // restore by simply keeping rem_t when the trial subtraction borrows
      if (!diff[XLEN]) begin
        acc_nx = diff[XLEN-1:0];
        sh_nx  = {sh[XLEN-2:0], 1'b1};
      end else begin
        acc_nx = rem_t[XLEN-1:0];
        sh_nx  = {sh[XLEN-2:0], 1'b0};
      end
    end else begin
      if (dv[0]) acc_nx = acc + sh;
      sh_nx = sh << 1;
      dv_nx = dv >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      div_q <= div_mode;
      neg_q <= a_neg_p0 ^ b_neg_p0;
      neg_r <= a_neg_p0;
      acc   <= '0;
      sh    <= div_mode ? mag_a_p0 : op_a;
      dv    <= div_mode ? mag_b_p0 : op_b;
    end else if (busy) begin
      sh  <= sh_nx;
      dv  <= dv_nx;
      acc <= acc_nx;
    end
  end

  assign product   = acc;
  assign quotient  = neg_q ? -sh : sh;
  assign remainder = neg_r ? -acc : acc;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decode, single-cycle datapath, iterative MUL/DIV and
// valid/ready handshake with held output registers.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [3:0]      alu_ctrl
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic [3:0] c;
    c = ALU_ILL;
    case (op)
      ALU_OP_ADD: c = ALU_ADD;
      ALU_OP_SUB: c = ALU_SUB;
      ALU_OP_RTYPE: begin
        if (f7 == FUNCT7_BASE) begin
          c = base_code(f3);
        end else if (f7 == FUNCT7_ALT) begin
          if (f3 == 3'b000)      c = ALU_SUB;
          else if (f3 == 3'b101) c = ALU_SRA;
        end else if (f7 == FUNCT7_MEXT && M_EXT) begin
          case (f3)
            3'b000:  c = ALU_MUL;
            3'b100:  c = ALU_DIV;
            3'b101:  c = ALU_DIVU;
            3'b110:  c = ALU_REM;
            3'b111:  c = ALU_REMU;
            default: c = ALU_ILL;
          endcase
        end
      end
      default: begin
        // I-type: funct7 is immediate bits except for the shift encodings
        case (f3)
          3'b001: if (f7 == FUNCT7_BASE) c = ALU_SLL;
          3'b101: begin
            if (f7 == FUNCT7_BASE)     c = ALU_SRL;
            else if (f7 == FUNCT7_ALT) c = ALU_SRA;
          end
          default: c = base_code(f3);
        endcase
      end
    endcase
    return c;
  endfunction

  // Divide-class codes reach here only for divide-by-zero or signed overflow
  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] c,
                                                  input logic signed [XLEN-1:0] a,
                                                  input logic signed [XLEN-1:0] b);
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] r;
    shamt = b[SHW-1:0];
    case (c)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << shamt;
      ALU_SRL:  r = $unsigned(a) >> shamt;
      ALU_SRA:  r = $unsigned(a >>> shamt);
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      ALU_DIV, ALU_DIVU: r = (b == '0) ? '1 : a;
      ALU_REM, ALU_REMU: r = (b == '0) ? a : '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [1:0]             state;
  logic                   accept_p0;
  logic [3:0]             ctrl_p0;
  logic                   is_md_p0;
  logic                   is_div_p0;
  logic                   div_special_p0;
  logic                   iter_start_p0;
  logic signed [XLEN-1:0] a_p0;
  logic signed [XLEN-1:0] b_p0;
  logic [XLEN-1:0]        single_p0;

  logic                   md_last;
  logic [XLEN-1:0]        md_product;
  logic [XLEN-1:0]        md_quotient;
  logic [XLEN-1:0]        md_remainder;
  logic [XLEN-1:0]        md_res_p1;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept_p0 = in_valid && in_ready;

  assign a_p0      = op_a;
  assign b_p0      = op_b;
  assign ctrl_p0   = decode(alu_op, funct3, funct7);
  assign is_md_p0  = is_muldiv(ctrl_p0);
  assign is_div_p0 = is_md_p0 && (ctrl_p0 != ALU_MUL);
  assign div_special_p0 = (op_b == '0) ||
                          ((op_a == MIN_NEG) && (op_b == '1) &&
                           ((ctrl_p0 == ALU_DIV) || (ctrl_p0 == ALU_REM)));
  assign iter_start_p0 = accept_p0 && is_md_p0 && !(is_div_p0 && div_special_p0);
  assign single_p0     = alu_compute(ctrl_p0, a_p0, b_p0);

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (iter_start_p0),
    .div_mode  (is_div_p0),
    .sgn       ((ctrl_p0 == ALU_DIV) || (ctrl_p0 == ALU_REM)),
    .op_a      (op_a),
    .op_b      (op_b),
    .last      (md_last),
    .product   (md_product),
    .quotient  (md_quotient),
    .remainder (md_remainder)
  );

  always_comb begin
    case (alu_ctrl)
      ALU_MUL:           md_res_p1 = md_product;
      ALU_DIV, ALU_DIVU: md_res_p1 = md_quotient;
      default:           md_res_p1 = md_remainder;
    endcase
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
      alu_ctrl  <= ALU_ILL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_p0) begin
            alu_ctrl <= ctrl_p0;
            if (iter_start_p0) begin
              state     <= (ctrl_p0 == ALU_MUL) ? ST_MUL : ST_DIV;
              out_valid <= 1'b0;
            end else begin
              result    <= single_p0;
              zero      <= (single_p0 == '0);
              illegal   <= (ctrl_p0 == ALU_ILL);
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_last) state <= ST_DONE;
        end
        default: begin
          result    <= md_res_p1;
          zero      <= (md_res_p1 == '0);
          illegal   <= 1'b0;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [3:0]  alu_ctrl;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        ill;
    logic [3:0]  c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc_cnt = 0;

  alu_exec_unit #(.XLEN(32), .M_EXT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .alu_ctrl  (alu_ctrl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got result %h expected no output", result);
      end else begin
        mon_e = sb.pop_front();
        chk("result",   64'(result),   64'(mon_e.r));
        chk("zero",     64'(zero),     64'(mon_e.z));
        chk("illegal",  64'(illegal),  64'(mon_e.ill));
        chk("alu_ctrl", 64'(alu_ctrl), 64'(mon_e.c));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ec, input bit push);
    int n;
    exp_t e;
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
      @(posedge clk);
      #1 in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.r = er; e.z = (er == 32'h0); e.ill = (ec == 4'hF); e.c = ec;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_queue_size", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   lat;
    bit   busy_ok;
    logic [31:0] held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_zero",      64'(zero),      64'd1);
    chk("rst_illegal",   64'(illegal),   64'd0);
    chk("rst_alu_ctrl",  64'(alu_ctrl),  64'hF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle ops, issued back to back
    c0 = cyc_cnt;
    issue(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0110, 1);
    chk("sub_latency1_valid", 64'(out_valid), 64'd1);
    issue(2'b00, 3'b000, 7'b0,       32'd10, 32'd20, 32'd30, 4'b0010, 1);
    issue(2'b01, 3'b000, 7'b0,       32'd9, 32'd9, 32'd0, 4'b0110, 1);
    issue(2'b10, 3'b111, 7'b0,       32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1);
    chk("back_to_back_cycles", 64'(cyc_cnt - c0), 64'd4);
    issue(2'b10, 3'b110, 7'b0,       32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 4'b0001, 1);
    issue(2'b10, 3'b100, 7'b0,       32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 4'b0011, 1);
    issue(2'b10, 3'b010, 7'b0,       32'hFFFF_FFFF, 32'd1, 32'd1, 4'b1000, 1);
    issue(2'b10, 3'b011, 7'b0,       32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1001, 1);
    issue(2'b10, 3'b001, 7'b0,       32'd1, 32'h3F, 32'h8000_0000, 4'b0100, 1);
    issue(2'b10, 3'b101, 7'b0,       32'h8000_0000, 32'd4, 32'h0800_0000, 4'b0101, 1);
    issue(2'b10, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b0111, 1);
    issue(2'b11, 3'b000, 7'b1010101, 32'd5, 32'hFFFF_FFFF, 32'd4, 4'b0010, 1);
    issue(2'b11, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b0111, 1);
    // Illegal encodings
    issue(2'b10, 3'b000, 7'b1111111, 32'd5, 32'd7, 32'd0, 4'b1111, 1);
    issue(2'b11, 3'b001, 7'b0100000, 32'd5, 32'd1, 32'd0, 4'b1111, 1);
    issue(2'b10, 3'b001, 7'b0100000, 32'd5, 32'd1, 32'd0, 4'b1111, 1);
    issue(2'b10, 3'b001, 7'b0000001, 32'd5, 32'd1, 32'd0, 4'b1111, 1);
    wait_drain();

    // MUL latency and stall
    issue(2'b10, 3'b000, 7'b0000001, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 4'b1010, 1);
    busy_ok = 1'b1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("mul_latency", 64'(lat), 64'd33);
    chk("mul_stall_in_ready", 64'(busy_ok), 64'd1);
    wait_drain();
    issue(2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 4'b1010, 1);
    wait_drain();

    // Divide family, including special cases
    issue(2'b10, 3'b100, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4'b1011, 1);
    issue(2'b10, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4'b1101, 1);
    issue(2'b10, 3'b100, 7'b0000001, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 4'b1011, 1);
    issue(2'b10, 3'b110, 7'b0000001, 32'd100, 32'hFFFF_FFF9, 32'd2, 4'b1101, 1);
    issue(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd14, 4'b1100, 1);
    issue(2'b10, 3'b111, 7'b0000001, 32'd100, 32'd7, 32'd2, 4'b1110, 1);
    issue(2'b10, 3'b101, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 4'b1100, 1);
    wait_drain();
    issue(2'b10, 3'b101, 7'b0000001, 32'd7, 32'd0, 32'hFFFF_FFFF, 4'b1100, 1);
    chk("divu_by_zero_latency1", 64'(out_valid), 64'd1);
    issue(2'b10, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1011, 1);
    chk("div_overflow_latency1", 64'(out_valid), 64'd1);
    issue(2'b10, 3'b110, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 4'b1101, 1);
    issue(2'b10, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 4'b1101, 1);
    wait_drain();

    // Output hold under backpressure, then drain+accept in one cycle
    out_ready = 1'b0;
    issue(2'b00, 3'b000, 7'b0, 32'h11, 32'h22, 32'h33, 4'b0010, 1);
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_state", {30'd0, out_valid, in_ready, result},
          {30'd0, 1'b1, 1'b0, held});
    end
    out_ready = 1'b1;
    c0 = cyc_cnt;
    issue(2'b10, 3'b100, 7'b0, 32'hAAAA_0000, 32'h0000_5555, 32'hAAAA_5555, 4'b0011, 1);
    chk("drain_accept_cycles", 64'(cyc_cnt - c0), 64'd1);
    chk("drain_accept_no_bubble", 64'(out_valid), 64'd1);
    wait_drain();

    // Reset in the middle of a divide
    issue(2'b10, 3'b100, 7'b0000001, 32'd1000, 32'd3, 32'd0, 4'b1011, 0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    chk("midrst_alu_ctrl",  64'(alu_ctrl),  64'hF);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_late_result", 64'(out_valid), 64'd0);
    issue(2'b00, 3'b000, 7'b0, 32'd2, 32'd3, 32'd5, 4'b0010, 1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
